// File: rtl/tx_frame_src.sv
// Framed PN symbol source for the PSK modulator AXIS input.
// Alternating preamble, then PN payload; BPSK/QPSK chosen per frame.
module tx_frame_src #(
  parameter int BYTES      = 1,
  parameter int PN_N       = 5,
  parameter int FRAME_LEN  = 32,
  parameter int PRE_LEN    = 8,
  parameter int GAP_CYCLES = 0,
  parameter int RESEED     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode_bpsk,
  output logic [BYTES*8-1:0] data_tdata,
  output logic               data_tvalid,
  input  logic               data_tready,
  output logic               data_tlast,
  output logic               data_tuser,
  output logic               busy,
  output logic [15:0]        frame_cnt
);

  localparam int BITS = BYTES * 8;
  localparam int TAPB = (PN_N == 3) ? 2 : (PN_N == 4) ? 3 :
                        (PN_N == 5) ? 3 : (PN_N == 6) ? 5 :
                        (PN_N == 7) ? 6 : 5;
  localparam int MAXL = (PRE_LEN > FRAME_LEN) ? PRE_LEN : FRAME_LEN;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] PRE_END = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] FRM_END = CW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GAP_END = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_PRE, S_PAY, S_GAP
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt, w_cnt_inc;
  logic [GW-1:0]   r_gcnt, w_gcnt;
  logic [PN_N-1:0] r_lfsr, w_lfsr, w_lfsr_adv;
  logic [1:0]      r_sym, w_sym;
  logic            r_valid, w_valid;
  logic            r_last, w_last;
  logic            r_user, w_user;
  logic            r_busy;
  logic [15:0]     r_fcnt, w_fcnt;
  logic            w_hs, w_start, w_stop;

  function automatic logic [PN_N-1:0] shl(input logic [PN_N-1:0] l);
    return {l[PN_N-2:0], l[PN_N-1] ^ l[TAPB-1]};
  endfunction

  function automatic logic [1:0] sym_pre(input logic k0, input logic bp);
    return {~k0, bp ? 1'b0 : ~k0};
  endfunction

  // QPSK's second bit is what lands in the MSB after one shift
  function automatic logic [1:0] sym_pay(input logic [PN_N-1:0] l,
                                         input logic bp);
    return {l[PN_N-1], bp ? 1'b0 : l[PN_N-2]};
  endfunction

  assign w_hs       = r_valid & data_tready;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_lfsr_adv = r_user ? shl(r_lfsr) : shl(shl(r_lfsr));

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_gcnt  = r_gcnt;
    w_lfsr  = r_lfsr;
    w_sym   = r_sym;
    w_valid = r_valid;
    w_last  = r_last;
    w_user  = r_user;
    w_fcnt  = r_fcnt;
    w_start = 1'b0;
    w_stop  = 1'b0;
    unique case (r_state)
      S_IDLE: w_start = en;
      S_PRE: begin
        if (w_hs) begin
          if (r_cnt == PRE_END) begin
            w_state = S_PAY;
            w_cnt   = '0;
            w_sym   = sym_pay(r_lfsr, r_user);
            w_last  = (FRAME_LEN == 1);
          end else begin
            w_cnt = w_cnt_inc;
            w_sym = sym_pre(w_cnt_inc[0], r_user);
          end
        end
      end
      S_PAY: begin
        if (w_hs) begin
          w_lfsr = w_lfsr_adv;
          if (r_cnt == FRM_END) begin
            w_fcnt = r_fcnt + 16'd1;
            if (GAP_CYCLES > 0) begin
              w_state = S_GAP;
              w_gcnt  = '0;
              w_valid = 1'b0;
              w_last  = 1'b0;
              w_sym   = '0;
            end else if (en) begin
              w_start = 1'b1;
            end else begin
              w_stop = 1'b1;
            end
          end else begin
            w_cnt  = w_cnt_inc;
            w_sym  = sym_pay(w_lfsr_adv, r_user);
            w_last = (w_cnt_inc == FRM_END);
          end
        end
      end
      S_GAP: begin
        w_gcnt = r_gcnt + 1'b1;
        if (r_gcnt == GAP_END) begin
          if (en) w_start = 1'b1;
          else    w_stop  = 1'b1;
        end
      end
      default: w_stop = 1'b1;
    endcase
    // frame start: w_lfsr already holds the advanced state when leaving PAY
    if (w_start) begin
      w_user  = mode_bpsk;
      w_lfsr  = (RESEED != 0) ? '1 : w_lfsr;
      w_valid = 1'b1;
      w_cnt   = '0;
      if (PRE_LEN > 0) begin
        w_state = S_PRE;
        w_sym   = sym_pre(1'b0, mode_bpsk);
        w_last  = 1'b0;
      end else begin
        w_state = S_PAY;
        w_sym   = sym_pay(w_lfsr, mode_bpsk);
        w_last  = (FRAME_LEN == 1);
      end
    end
    if (w_stop) begin
      w_state = S_IDLE;
      w_valid = 1'b0;
      w_last  = 1'b0;
      w_sym   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_lfsr  <= '1;
      r_sym   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_user  <= 1'b0;
      r_busy  <= 1'b0;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_gcnt  <= w_gcnt;
      r_lfsr  <= w_lfsr;
      r_sym   <= w_sym;
      r_valid <= w_valid;
      r_last  <= w_last;
      r_user  <= w_user;
      r_busy  <= (w_state != S_IDLE);
      r_fcnt  <= w_fcnt;
    end
  end

  assign data_tdata  = {{(BITS-2){1'b0}}, r_sym};
  assign data_tvalid = r_valid;
  assign data_tlast  = r_last;
  assign data_tuser  = r_user;
  assign busy        = r_busy;
  assign frame_cnt   = r_fcnt;

endmodule

// File: tb/tb_tx_frame_src.sv
// Directed bench for tx_frame_src: three configs, PN3 sequences,
// QPSK pairing, preamble, stalls, gap/stop, reseed and reset.
module tb_tx_frame_src;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v[3];
  logic        en_v[3];
  logic        md_v[3];
  logic        rdy_v[3];
  logic [7:0]  td[3];
  logic        tv[3];
  logic        tl[3];
  logic        tu[3];
  logic        bz[3];
  logic [15:0] fc[3];

  tx_frame_src #(.BYTES(1), .PN_N(3), .FRAME_LEN(7), .PRE_LEN(0),
                 .GAP_CYCLES(0), .RESEED(0)) u0 (
    .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .mode_bpsk(md_v[0]),
    .data_tdata(td[0]), .data_tvalid(tv[0]), .data_tready(rdy_v[0]),
    .data_tlast(tl[0]), .data_tuser(tu[0]), .busy(bz[0]),
    .frame_cnt(fc[0]));

  tx_frame_src #(.BYTES(1), .PN_N(3), .FRAME_LEN(4), .PRE_LEN(0),
                 .GAP_CYCLES(0), .RESEED(0)) u1 (
    .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .mode_bpsk(md_v[1]),
    .data_tdata(td[1]), .data_tvalid(tv[1]), .data_tready(rdy_v[1]),
    .data_tlast(tl[1]), .data_tuser(tu[1]), .busy(bz[1]),
    .frame_cnt(fc[1]));

  tx_frame_src #(.BYTES(1), .PN_N(3), .FRAME_LEN(5), .PRE_LEN(4),
                 .GAP_CYCLES(3), .RESEED(1)) u2 (
    .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .mode_bpsk(md_v[2]),
    .data_tdata(td[2]), .data_tvalid(tv[2]), .data_tready(rdy_v[2]),
    .data_tlast(tl[2]), .data_tuser(tu[2]), .busy(bz[2]),
    .frame_cnt(fc[2]));

  typedef struct packed {
    logic        r;
    logic        v;
    logic [1:0]  s;
    logic        l;
    logic [15:0] fc;
  } vec_t;

  typedef struct packed {
    logic       v;
    logic [1:0] s;
    logic       l;
    logic       b;
  } e2_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic r, input logic v,
                              input logic [1:0] s, input logic l,
                              input logic [15:0] f);
    vec_t x;
    x.r = r; x.v = v; x.s = s; x.l = l; x.fc = f;
    return x;
  endfunction

  vec_t       tbl[21];
  logic [1:0] pn[7];
  logic [1:0] qx[8];
  logic       ql[8];
  e2_t        e2[26];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // frame 1 free-flowing, frame 2 with stalls; BPSK bits 1110010
    tbl[0]  = mk(1, 1, 2'd2, 0, 0);
    tbl[1]  = mk(1, 1, 2'd2, 0, 0);
    tbl[2]  = mk(1, 1, 2'd2, 0, 0);
    tbl[3]  = mk(1, 1, 2'd0, 0, 0);
    tbl[4]  = mk(1, 1, 2'd0, 0, 0);
    tbl[5]  = mk(1, 1, 2'd2, 0, 0);
    tbl[6]  = mk(1, 1, 2'd0, 1, 0);
    tbl[7]  = mk(1, 1, 2'd2, 0, 1);
    tbl[8]  = mk(0, 1, 2'd2, 0, 1);
    tbl[9]  = mk(0, 1, 2'd2, 0, 1);
    tbl[10] = mk(1, 1, 2'd2, 0, 1);
    tbl[11] = mk(0, 1, 2'd2, 0, 1);
    tbl[12] = mk(1, 1, 2'd2, 0, 1);
    tbl[13] = mk(1, 1, 2'd0, 0, 1);
    tbl[14] = mk(0, 1, 2'd0, 0, 1);
    tbl[15] = mk(1, 1, 2'd0, 0, 1);
    tbl[16] = mk(0, 1, 2'd2, 0, 1);
    tbl[17] = mk(1, 1, 2'd2, 0, 1);
    tbl[18] = mk(0, 1, 2'd0, 1, 1);
    tbl[19] = mk(0, 1, 2'd0, 1, 1);
    tbl[20] = mk(1, 1, 2'd0, 1, 1);
    pn = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd0};
    qx = '{2'd3, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2, 2'd3};
    ql = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    begin
      int k;
      k = 0;
      for (int f = 0; f < 2; f++) begin
        for (int p = 0; p < 4; p++) begin
          e2[k] = '{1'b1, (p % 2 == 0) ? 2'd2 : 2'd0, 1'b0, 1'b1};
          k++;
        end
        for (int p = 0; p < 5; p++) begin
          e2[k] = '{1'b1, pn[p], (p == 4), 1'b1};
          k++;
        end
        for (int p = 0; p < 3; p++) begin
          e2[k] = '{1'b0, 2'd0, 1'b0, 1'b1};
          k++;
        end
      end
      e2[24] = '{1'b0, 2'd0, 1'b0, 1'b0};
      e2[25] = '{1'b0, 2'd0, 1'b0, 1'b0};
    end

    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b1; en_v[i] = 1'b0; md_v[i] = 1'b1; rdy_v[i] = 1'b1;
    end

    // u0: BPSK, PN3, stalls, reset mid-payload
    en_v[0] = 1'b1;
    step(); step();
    chk("u0_reset", {tv[0], td[0], tl[0], tu[0], bz[0], fc[0]}, '0);
    rst_v[0] = 1'b0;
    for (int i = 0; i < 21; i++) begin
      step();
      rdy_v[0] = tbl[i].r;
      chk($sformatf("u0_vec%0d", i),
          {tv[0], td[0], tl[0], tu[0], bz[0], fc[0]},
          {tbl[i].v, 6'd0, tbl[i].s, tbl[i].l, 1'b1, 1'b1, tbl[i].fc});
    end
    step();
    rdy_v[0] = 1'b1;
    chk("u0_fc2", {tv[0], td[0], fc[0]}, {1'b1, 8'd2, 16'd2});
    step(); step();
    rst_v[0] = 1'b1;
    step();
    chk("u0_midrst", {tv[0], td[0], tl[0], tu[0], bz[0], fc[0]}, '0);
    rst_v[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("u0_restart%0d", i), {tv[0], td[0], tl[0]},
          {1'b1, 6'd0, pn[i], (i == 6)});
    end
    step();
    chk("u0_fc_after", {32'(fc[0])}, 32'd1);

    // u1: QPSK, two frames free-running
    md_v[1] = 1'b0; en_v[1] = 1'b1;
    step(); step();
    rst_v[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("u1_qpsk%0d", i), {tv[1], td[1], tl[1], tu[1]},
          {1'b1, 6'd0, qx[i], ql[i], 1'b0});
    end

    // u2: preamble, gap, reseed, en drop, mode change ignored
    step(); step();
    rst_v[2] = 1'b0;
    step();
    chk("u2_idle", {tv[2], bz[2]}, 2'b00);
    en_v[2] = 1'b1;
    for (int i = 0; i < 26; i++) begin
      step();
      chk($sformatf("u2_seq%0d", i),
          tv[2] ? {tv[2], td[2][1:0], tl[2], bz[2]}
                : {tv[2], 3'b000, bz[2]},
          e2[i]);
      if (e2[i].v) chk($sformatf("u2_user%0d", i), {31'd0, tu[2]}, 1);
      if (i == 5)  md_v[2] = 1'b0;
      if (i == 9)  md_v[2] = 1'b1;
      if (i == 17) en_v[2] = 1'b0;
    end
    chk("u2_fc", {16'd0, fc[2]}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
